// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back/write-allocate data cache between the CPU data port and block-capable data memory.
// Optional hit/miss counters are built when DCACHE_STATS_EN is defined.
module dcache_ctrl #(
  parameter int          LINES   = 16,
  parameter logic [31:0] IO_BASE = 32'h11000000
) (
  input  logic         MEM_CLK,
  input  logic         RST,
  input  logic [31:0]  CPU_ADDR,
  input  logic         CPU_RD,
  input  logic         CPU_WR,
  input  logic [31:0]  CPU_WDATA,
  output logic [31:0]  CPU_RDATA,
  output logic         CPU_STALL,
  output logic [31:0]  MEM_ADDR2,
  output logic         MEM_READ2,
  output logic         MEM_WRITE2,
  output logic         write_block,
  output logic [127:0] MEM_WBLK,
  input  logic [127:0] MEM_RBLK,
`ifdef DCACHE_STATS_EN
  output logic [31:0]  HIT_CNT,
  output logic [31:0]  MISS_CNT,
`endif
  output logic [2:0]   DBG_STATE
);

  localparam int IDX  = $clog2(LINES);
  localparam int TAGW = 28 - IDX;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WB        = 3'd1,
    S_FILL_REQ  = 3'd2,
    S_FILL_WAIT = 3'd3,
    S_UNC       = 3'd4,
    S_UDONE     = 3'd5
  } state_t;

  state_t state_q, state_d;

  logic [LINES-1:0] valid_q;
  logic [LINES-1:0] dirty_q;
  logic [TAGW-1:0]  tag_q  [LINES];
  logic [31:0]      data_q [LINES][4];

  logic [IDX-1:0]  idx;
  logic [1:0]      off;
  logic [TAGW-1:0] tag;
  logic            req, unc, hit, wr_hit;
  logic            unused_bits;

  assign idx         = CPU_ADDR[3+IDX:4];
  assign off         = CPU_ADDR[3:2];
  assign tag         = CPU_ADDR[31:4+IDX];
  assign unused_bits = ^CPU_ADDR[1:0];
  assign req         = CPU_RD | CPU_WR;
  assign unc         = (CPU_ADDR >= IO_BASE);
  assign hit         = !unc && valid_q[idx] && (tag_q[idx] == tag);
  // RD together with WR is a write.
  assign wr_hit      = (state_q == S_IDLE) && CPU_WR && hit;

  // Handshake: the CPU holds ADDR/RD/WR/WDATA while CPU_STALL=1; a request
  // completes in the cycle where req=1 and CPU_STALL=0 (IDLE hit or UDONE).
  assign CPU_STALL = req && !(((state_q == S_IDLE) && hit) || (state_q == S_UDONE));
  assign DBG_STATE = state_q;

  always_ff @(posedge MEM_CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_FILL_WAIT) begin
        valid_q[idx] <= 1'b1;
        dirty_q[idx] <= 1'b0;
      end else if (wr_hit) begin
        dirty_q[idx] <= 1'b1;
      end
    end
  end

  // Tags and line data are not reset; valid alone qualifies them.
  always_ff @(posedge MEM_CLK) begin
    if (state_q == S_FILL_WAIT) begin
      tag_q[idx]     <= tag;
      data_q[idx][0] <= MEM_RBLK[31:0];
      data_q[idx][1] <= MEM_RBLK[63:32];
      data_q[idx][2] <= MEM_RBLK[95:64];
      data_q[idx][3] <= MEM_RBLK[127:96];
    end else if (wr_hit) begin
      data_q[idx][off] <= CPU_WDATA;
    end
  end

  always_comb begin
    state_d     = state_q;
    MEM_READ2   = 1'b0;
    MEM_WRITE2  = 1'b0;
    write_block = 1'b0;
    MEM_ADDR2   = 32'h0;
    MEM_WBLK    = 128'h0;
    CPU_RDATA   = data_q[idx][off];
    case (state_q)
      S_IDLE: begin
        if (req && !hit) begin
          if (unc)                              state_d = S_UNC;
          else if (valid_q[idx] && dirty_q[idx]) state_d = S_WB;
          else                                  state_d = S_FILL_REQ;
        end
      end
      S_WB: begin
        MEM_WRITE2  = 1'b1;
        write_block = 1'b1;
        MEM_ADDR2   = {tag_q[idx], idx, 4'b0000};
        MEM_WBLK    = {data_q[idx][3], data_q[idx][2], data_q[idx][1], data_q[idx][0]};
        state_d     = S_FILL_REQ;
      end
      S_FILL_REQ: begin
        MEM_READ2 = 1'b1;
        MEM_ADDR2 = {CPU_ADDR[31:4], 4'b0000};
        state_d   = S_FILL_WAIT;
      end
      S_FILL_WAIT: state_d = S_IDLE;
      S_UNC: begin
        MEM_ADDR2 = CPU_ADDR;
        if (CPU_WR) begin
          MEM_WRITE2 = 1'b1;
          MEM_WBLK   = {96'h0, CPU_WDATA};
        end else begin
          MEM_READ2 = 1'b1;
        end
        state_d = S_UDONE;
      end
      S_UDONE: begin
        CPU_RDATA = MEM_RBLK[31:0];
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef DCACHE_STATS_EN
  logic        retry_q;
  logic [31:0] hit_cnt_q, miss_cnt_q;

  // The IDLE cycle right after a fill is the miss completing, not a new hit.
  always_ff @(posedge MEM_CLK or posedge RST) begin
    if (RST) begin
      retry_q    <= 1'b0;
      hit_cnt_q  <= 32'h0;
      miss_cnt_q <= 32'h0;
    end else begin
      retry_q <= (state_q == S_FILL_WAIT);
      if ((state_q == S_IDLE) && req && hit && !retry_q)
        hit_cnt_q <= hit_cnt_q + 32'h1;
      if ((state_q == S_IDLE) && req && !unc && !hit)
        miss_cnt_q <= miss_cnt_q + 32'h1;
    end
  end

  assign HIT_CNT  = hit_cnt_q;
  assign MISS_CNT = miss_cnt_q;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Bench for dcache_ctrl: table of directed requests against a block memory model,
// plus hand-written reset-mid-fill and counter sequences.
module tb_dcache_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  cpu_addr, cpu_wdata, cpu_rdata;
  logic         cpu_rd, cpu_wr, cpu_stall;
  logic [31:0]  mem_addr;
  logic         mem_read, mem_write, mem_block;
  logic [127:0] mem_wblk;
  logic [127:0] mem_rblk;
  logic [2:0]   dbg_state;
`ifdef DCACHE_STATS_EN
  logic [31:0]  hit_cnt, miss_cnt;
`endif

  dcache_ctrl dut (
    .MEM_CLK     (clk),
    .RST         (rst),
    .CPU_ADDR    (cpu_addr),
    .CPU_RD      (cpu_rd),
    .CPU_WR      (cpu_wr),
    .CPU_WDATA   (cpu_wdata),
    .CPU_RDATA   (cpu_rdata),
    .CPU_STALL   (cpu_stall),
    .MEM_ADDR2   (mem_addr),
    .MEM_READ2   (mem_read),
    .MEM_WRITE2  (mem_write),
    .write_block (mem_block),
    .MEM_WBLK    (mem_wblk),
    .MEM_RBLK    (mem_rblk),
`ifdef DCACHE_STATS_EN
    .HIT_CNT     (hit_cnt),
    .MISS_CNT    (miss_cnt),
`endif
    .DBG_STATE   (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- memory model ----------------
  logic [31:0]  mem    [0:16383];
  logic [31:0]  io_mem [0:15];
  bit           mem_loaded = 1'b0;
  int           rd_cnt = 0;
  int           wr_cnt = 0;
  logic [31:0]  last_wr_addr = '0;
  logic [127:0] last_wr_blk = '0;
  logic         last_wr_block = 1'b0;

  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 16384; i++) mem[i] = 32'h5000_0000 | i;
      mem[32'h40] = 32'hDEADBEEF;
      for (int i = 0; i < 16; i++) io_mem[i] = 32'h0;
      io_mem[0] = 32'h0000_00A5;
      mem_loaded <= 1'b1;
      mem_rblk   <= '0;
    end else begin
      if (mem_read) begin
        rd_cnt <= rd_cnt + 1;
        if (mem_addr >= 32'h1100_0000)
          mem_rblk <= {96'h0, io_mem[mem_addr[5:2]]};
        else
          mem_rblk <= {mem[{mem_addr[15:4], 2'd3}], mem[{mem_addr[15:4], 2'd2}],
                       mem[{mem_addr[15:4], 2'd1}], mem[{mem_addr[15:4], 2'd0}]};
      end
      if (mem_write) begin
        wr_cnt        <= wr_cnt + 1;
        last_wr_addr  <= mem_addr;
        last_wr_blk   <= mem_wblk;
        last_wr_block <= mem_block;
        if (mem_block) begin
          mem[{mem_addr[15:4], 2'd0}] <= mem_wblk[31:0];
          mem[{mem_addr[15:4], 2'd1}] <= mem_wblk[63:32];
          mem[{mem_addr[15:4], 2'd2}] <= mem_wblk[95:64];
          mem[{mem_addr[15:4], 2'd3}] <= mem_wblk[127:96];
        end else begin
          io_mem[mem_addr[5:2]] <= mem_wblk[31:0];
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic do_req(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, output int stalls,
                        output logic [31:0] rdata);
    cpu_rd = rd; cpu_wr = wr; cpu_addr = addr; cpu_wdata = wdata;
    stalls = 0;
    #1;
    while (cpu_stall === 1'b1 && stalls < 20) begin
      stalls++;
      @(negedge clk);
      #1;
    end
    checks++;
    if (cpu_stall !== 1'b0) begin
      errors++;
      $display("FAIL timeout addr=%0h: stall=%b after %0d cycles, required 0", addr, cpu_stall, stalls);
    end
    rdata = cpu_rdata;
    @(negedge clk);
    cpu_rd = 1'b0; cpu_wr = 1'b0;
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          exp_stall;
    logic        chk_rdata;
    logic [31:0] exp_rdata;
    int          exp_rd;
    int          exp_wr;
  } vec_t;

  vec_t vecs[18];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          stalls, r0, w0;
    logic [31:0] rdata;

    vecs[0]  = '{1'b1, 1'b0, 32'h100,      32'h0,        3, 1'b1, 32'hDEADBEEF, 1, 0};
    vecs[1]  = '{1'b1, 1'b0, 32'h104,      32'h0,        0, 1'b1, 32'h50000041, 0, 0};
    vecs[2]  = '{1'b0, 1'b1, 32'h100,      32'h12345678, 0, 1'b0, 32'h0,        0, 0};
    vecs[3]  = '{1'b1, 1'b0, 32'h200,      32'h0,        4, 1'b1, 32'h50000080, 1, 1};
    vecs[4]  = '{1'b1, 1'b0, 32'h100,      32'h0,        3, 1'b1, 32'h12345678, 1, 0};
    vecs[5]  = '{1'b1, 1'b0, 32'h11000000, 32'h0,        2, 1'b1, 32'h000000A5, 1, 0};
    vecs[6]  = '{1'b0, 1'b1, 32'h11000004, 32'h55,       2, 1'b0, 32'h0,        0, 1};
    vecs[7]  = '{1'b1, 1'b0, 32'h104,      32'h0,        0, 1'b1, 32'h50000041, 0, 0};
    vecs[8]  = '{1'b0, 1'b1, 32'h340,      32'hCAFEF00D, 3, 1'b0, 32'h0,        1, 0};
    vecs[9]  = '{1'b1, 1'b0, 32'h340,      32'h0,        0, 1'b1, 32'hCAFEF00D, 0, 0};
    vecs[10] = '{1'b1, 1'b0, 32'h040,      32'h0,        4, 1'b1, 32'h50000010, 1, 1};
    vecs[11] = '{1'b1, 1'b0, 32'h344,      32'h0,        3, 1'b1, 32'h500000D1, 1, 0};
    vecs[12] = '{1'b1, 1'b0, 32'h340,      32'h0,        0, 1'b1, 32'hCAFEF00D, 0, 0};
    vecs[13] = '{1'b1, 1'b1, 32'h344,      32'h11112222, 0, 1'b0, 32'h0,        0, 0};
    vecs[14] = '{1'b1, 1'b0, 32'h344,      32'h0,        0, 1'b1, 32'h11112222, 0, 0};
    vecs[15] = '{1'b1, 1'b0, 32'h0F0,      32'h0,        3, 1'b1, 32'h5000003C, 1, 0};
    vecs[16] = '{1'b1, 1'b0, 32'h0FC,      32'h0,        0, 1'b1, 32'h5000003F, 0, 0};
    vecs[17] = '{1'b1, 1'b0, 32'h11000004, 32'h0,        2, 1'b1, 32'h00000055, 1, 0};

    rst = 1'b1; cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_state",  dbg_state, 3'd0);
    check("reset_stall",  cpu_stall, 1'b0);
    check("reset_read2",  mem_read,  1'b0);
    check("reset_write2", mem_write, 1'b0);
    check("reset_block",  mem_block, 1'b0);
    check("reset_addr2",  mem_addr,  32'h0);
    @(negedge clk);

    for (int i = 0; i < 18; i++) begin
      r0 = rd_cnt; w0 = wr_cnt;
      if (vecs[i].chk_rdata) exp_q.push_back(vecs[i].exp_rdata);
      do_req(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, stalls, rdata);
      check($sformatf("v%0d_stall", i), stalls, vecs[i].exp_stall);
      if (vecs[i].chk_rdata) check($sformatf("v%0d_rdata", i), rdata, exp_q.pop_front());
      check($sformatf("v%0d_mem_reads", i),  rd_cnt - r0, vecs[i].exp_rd);
      check($sformatf("v%0d_mem_writes", i), wr_cnt - w0, vecs[i].exp_wr);
      if (i == 3) begin
        check("wb1_addr",  last_wr_addr,       32'h100);
        check("wb1_block", last_wr_block,      1'b1);
        check("wb1_w0",    last_wr_blk[31:0],  32'h12345678);
        check("wb1_w1",    last_wr_blk[63:32], 32'h50000041);
      end
      if (i == 6) begin
        check("uncw_addr",  last_wr_addr,      32'h11000004);
        check("uncw_block", last_wr_block,     1'b0);
        check("uncw_data",  last_wr_blk[31:0], 32'h55);
      end
      if (i == 10) begin
        check("wb2_addr", last_wr_addr,       32'h340);
        check("wb2_w0",   last_wr_blk[31:0],  32'hCAFEF00D);
        check("wb2_w1",   last_wr_blk[63:32], 32'h500000D1);
      end
    end

    // Reset while the fill for 0x500 is in FILL_WAIT.
    cpu_rd = 1'b1; cpu_addr = 32'h500;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("midfill_state", dbg_state, 3'd3);
    rst = 1'b1;
    #1;
    check("midrst_state",  dbg_state, 3'd0);
    check("midrst_read2",  mem_read,  1'b0);
    check("midrst_write2", mem_write, 1'b0);
    cpu_rd = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    r0 = rd_cnt;
    do_req(1'b1, 1'b0, 32'h500, 32'h0, stalls, rdata);
    check("refill_stall", stalls, 3);
    check("refill_rdata", rdata,  32'h50000140);
    check("refill_reads", rd_cnt - r0, 1);
    do_req(1'b1, 1'b0, 32'h104, 32'h0, stalls, rdata);
    check("inval_stall", stalls, 3);
    check("inval_rdata", rdata,  32'h50000041);

`ifdef DCACHE_STATS_EN
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("cnt_hit_reset",  hit_cnt,  32'h0);
    check("cnt_miss_reset", miss_cnt, 32'h0);
    @(negedge clk);
    do_req(1'b1, 1'b0, 32'h600,      32'h0, stalls, rdata);
    do_req(1'b1, 1'b0, 32'h604,      32'h0, stalls, rdata);
    do_req(1'b1, 1'b0, 32'h608,      32'h0, stalls, rdata);
    do_req(1'b1, 1'b0, 32'h60C,      32'h0, stalls, rdata);
    do_req(1'b1, 1'b0, 32'h11000000, 32'h0, stalls, rdata);
    check("cnt_hit",  hit_cnt,  32'd3);
    check("cnt_miss", miss_cnt, 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
